// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready inter-stage buffer of DEPTH entries, with flush (NOP fill)
// and stall (freeze) control from the hazard unit.
module pipe_stage_buf #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 2,
    parameter logic [31:0] FLUSH_VAL  = 32'h0000_0013,
    parameter bit          READY_THRU = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic                       out_flushed_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Storage rounded up to a power of two so the pointer indexes it exactly.
    localparam int unsigned MEM_N = 1 << PTR_W;
    localparam logic [DATA_W-1:0] FLUSH_DATA = DATA_W'(FLUSH_VAL);

    if (DEPTH < 1) begin : g_depth_check
        $error("pipe_stage_buf: DEPTH must be >= 1");
    end

    logic [DATA_W-1:0] mem [MEM_N];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              flushed;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Handshake decode; flush and stall both block every transfer.
    assign in_ready_o  = !flush_i && !stall_i && (!full || (READY_THRU && out_ready_i));
    assign out_valid_o = !empty && !flush_i && !stall_i;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // Head stays visible during stall; only out_valid_o is gated.
    assign out_data_o    = empty ? FLUSH_DATA : mem[rd_ptr];
    assign out_flushed_o = flushed;
    assign count_o       = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            flushed <= 1'b0;
        end else if (flush_i) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            flushed <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr  <= ptr_inc(wr_ptr);
                flushed <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: three instances (D2/RT0, D1/RT1, D3/RT0) share stimulus.
module tb_pipe_stage_buf;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, flush, stall, in_valid, out_ready;
    logic [31:0] in_data;
    int          checks = 0;
    int          failures = 0;
    int          tgt = 0;

    logic        d2_in_ready, d2_out_valid, d2_flushed;
    logic [31:0] d2_out_data;
    logic [1:0]  d2_count;
    logic        d1_in_ready, d1_out_valid, d1_flushed;
    logic [31:0] d1_out_data;
    logic [0:0]  d1_count;
    logic        d3_in_ready, d3_out_valid, d3_flushed;
    logic [31:0] d3_out_data;
    logic [1:0]  d3_count;
    logic        tgt_ready;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(32), .DEPTH(2), .FLUSH_VAL(NOP), .READY_THRU(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
        .in_valid_i(in_valid), .in_ready_o(d2_in_ready), .in_data_i(in_data),
        .out_valid_o(d2_out_valid), .out_ready_i(out_ready), .out_data_o(d2_out_data),
        .out_flushed_o(d2_flushed), .count_o(d2_count));

    pipe_stage_buf #(.DATA_W(32), .DEPTH(1), .FLUSH_VAL(NOP), .READY_THRU(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
        .in_valid_i(in_valid), .in_ready_o(d1_in_ready), .in_data_i(in_data),
        .out_valid_o(d1_out_valid), .out_ready_i(out_ready), .out_data_o(d1_out_data),
        .out_flushed_o(d1_flushed), .count_o(d1_count));

    pipe_stage_buf #(.DATA_W(32), .DEPTH(3), .FLUSH_VAL(NOP), .READY_THRU(1'b0)) u_d3 (
        .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
        .in_valid_i(in_valid), .in_ready_o(d3_in_ready), .in_data_i(in_data),
        .out_valid_o(d3_out_valid), .out_ready_i(out_ready), .out_data_o(d3_out_data),
        .out_flushed_o(d3_flushed), .count_o(d3_count));

    assign tgt_ready = (tgt == 0) ? d2_in_ready : (tgt == 1) ? d1_in_ready : d3_in_ready;

    // Upstream must hold in_data while valid is back-pressured by the targeted instance.
    logic        hold_q = 1'b0;
    logic [31:0] hold_data_q = '0;
    always @(posedge clk) begin
        if (hold_q && in_valid) begin
            checks++;
            if (in_data !== hold_data_q) begin
                failures++;
                $display("FAIL proto_hold got=%0h exp=%0h", in_data, hold_data_q);
            end
        end
        hold_q      <= in_valid && !tgt_ready && !flush && !rst;
        hold_data_q <= in_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        tgt = 0;
        do_reset();
        checks++; if (d2_count !== 2'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", d2_count); end
        checks++; if (d2_out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", d2_out_valid); end
        checks++; if (d2_out_data !== NOP) begin failures++; $display("FAIL rst_data got=%0h exp=%0h", d2_out_data, NOP); end
        checks++; if (d2_flushed !== 1'b0) begin failures++; $display("FAIL rst_flushed got=%0b exp=0", d2_flushed); end
        checks++; if (d2_in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", d2_in_ready); end
    endtask

    task automatic test_fill_drain();
        tgt = 0;
        do_reset();
        in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
        tick();
        in_data = 32'h22;
        tick();
        checks++; if (d2_count !== 2'd2) begin failures++; $display("FAIL fill_count got=%0d exp=2", d2_count); end
        checks++; if (d2_in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%0b exp=0", d2_in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (d2_in_ready !== 1'b0) begin failures++; $display("FAIL full_no_thru got=%0b exp=0", d2_in_ready); end
        in_valid = 1'b0;
        #1;
        checks++; if (d2_out_valid !== 1'b1) begin failures++; $display("FAIL drain_valid got=%0b exp=1", d2_out_valid); end
        checks++; if (d2_out_data !== 32'h11) begin failures++; $display("FAIL drain_a got=%0h exp=11", d2_out_data); end
        tick();
        checks++; if (d2_count !== 2'd1) begin failures++; $display("FAIL drain_count1 got=%0d exp=1", d2_count); end
        checks++; if (d2_out_data !== 32'h22) begin failures++; $display("FAIL drain_b got=%0h exp=22", d2_out_data); end
        tick();
        checks++; if (d2_count !== 2'd0) begin failures++; $display("FAIL drain_count0 got=%0d exp=0", d2_count); end
        checks++; if (d2_out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty_valid got=%0b exp=0", d2_out_valid); end
        checks++; if (d2_out_data !== NOP) begin failures++; $display("FAIL drain_empty_data got=%0h exp=%0h", d2_out_data, NOP); end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        tgt = 1;
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            #1;
            checks++; if (d1_in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready[%0d] got=%0b exp=1", i, d1_in_ready); end
            tick();
            checks++; if (d1_out_data !== 32'(i)) begin failures++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, d1_out_data, i); end
            checks++; if (d1_count !== 1'b1) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, d1_count); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (d1_count !== 1'b0) begin failures++; $display("FAIL stream_end_count got=%0d exp=0", d1_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_q [$];
        int          exp_cnt [11] = '{1, 1, 2, 2, 3, 2, 2, 1, 1, 0, 0};
        logic        m_pop;
        logic        m_push;
        tgt = 2;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            in_valid = (c < 5); in_data = 32'(32'hA1 + c); out_ready = c[0];
            #1;
            m_pop  = (exp_q.size() > 0) && out_ready;
            m_push = in_valid && (exp_q.size() < 3);
            checks++; if (d3_in_ready !== (exp_q.size() < 3)) begin failures++; $display("FAIL wrap_ready[%0d] got=%0b exp=%0b", c, d3_in_ready, exp_q.size() < 3); end
            if (m_pop) begin
                checks++; if (d3_out_data !== exp_q[0]) begin failures++; $display("FAIL wrap_data[%0d] got=%0h exp=%0h", c, d3_out_data, exp_q[0]); end
                exp_q.pop_front();
            end
            if (m_push) exp_q.push_back(in_data);
            tick();
            checks++; if (32'(d3_count) !== 32'(exp_cnt[c])) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", c, d3_count, exp_cnt[c]); end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_flush();
        tgt = 0;
        do_reset();
        in_valid = 1'b1; in_data = 32'h31;
        tick();
        in_data = 32'h32;
        tick();
        flush = 1'b1; in_data = 32'h33;
        #1;
        checks++; if (d2_in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", d2_in_ready); end
        checks++; if (d2_out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", d2_out_valid); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (d2_count !== 2'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", d2_count); end
        checks++; if (d2_out_data !== NOP) begin failures++; $display("FAIL flush_data got=%0h exp=%0h", d2_out_data, NOP); end
        checks++; if (d2_flushed !== 1'b1) begin failures++; $display("FAIL flush_flag got=%0b exp=1", d2_flushed); end
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0; stall = 1'b1;
        tick();
        stall = 1'b0;
        #1;
        checks++; if (d2_flushed !== 1'b1) begin failures++; $display("FAIL flush_hold got=%0b exp=1", d2_flushed); end
        checks++; if (d2_count !== 2'd0) begin failures++; $display("FAIL flush_hold_count got=%0d exp=0", d2_count); end
        in_valid = 1'b1; in_data = 32'h44;
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (d2_flushed !== 1'b0) begin failures++; $display("FAIL flush_clear got=%0b exp=0", d2_flushed); end
        checks++; if (d2_out_data !== 32'h44) begin failures++; $display("FAIL flush_next got=%0h exp=44", d2_out_data); end
        checks++; if (d2_count !== 2'd1) begin failures++; $display("FAIL flush_next_count got=%0d exp=1", d2_count); end
    endtask

    task automatic test_stall();
        tgt = 0;
        do_reset();
        in_valid = 1'b1; in_data = 32'h51;
        tick();
        in_data = 32'h52;
        tick();
        stall = 1'b1; out_ready = 1'b1; in_data = 32'h53;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (d2_in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d] got=%0b exp=0", k, d2_in_ready); end
            checks++; if (d2_out_valid !== 1'b0) begin failures++; $display("FAIL stall_valid[%0d] got=%0b exp=0", k, d2_out_valid); end
            checks++; if (d2_count !== 2'd2) begin failures++; $display("FAIL stall_count[%0d] got=%0d exp=2", k, d2_count); end
            checks++; if (d2_out_data !== 32'h51) begin failures++; $display("FAIL stall_data[%0d] got=%0h exp=51", k, d2_out_data); end
            tick();
        end
        stall = 1'b0;
        #1;
        checks++; if (d2_out_valid !== 1'b1) begin failures++; $display("FAIL unstall_valid got=%0b exp=1", d2_out_valid); end
        tick();
        checks++; if (d2_count !== 2'd1) begin failures++; $display("FAIL unstall_count got=%0d exp=1", d2_count); end
        checks++; if (d2_out_data !== 32'h52) begin failures++; $display("FAIL unstall_data got=%0h exp=52", d2_out_data); end
        tick();
        checks++; if (d2_count !== 2'd1) begin failures++; $display("FAIL unstall_count2 got=%0d exp=1", d2_count); end
        checks++; if (d2_out_data !== 32'h53) begin failures++; $display("FAIL unstall_data2 got=%0h exp=53", d2_out_data); end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        tgt = 0;
        do_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (d2_flushed !== 1'b0) begin failures++; $display("FAIL rst_clears_flushed got=%0b exp=0", d2_flushed); end
        in_valid = 1'b1; in_data = 32'h61;
        tick();
        in_data = 32'h62;
        tick();
        checks++; if (d2_count !== 2'd2) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=2", d2_count); end
        out_ready = 1'b1; in_data = 32'h63; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (d2_count !== 2'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", d2_count); end
        checks++; if (d2_out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", d2_out_valid); end
        checks++; if (d2_flushed !== 1'b0) begin failures++; $display("FAIL rstmid_flushed got=%0b exp=0", d2_flushed); end
        checks++; if (d2_out_data !== NOP) begin failures++; $display("FAIL rstmid_data got=%0h exp=%0h", d2_out_data, NOP); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        test_reset();
        test_fill_drain();
        test_stream();
        test_wrap();
        test_flush();
        test_stall();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
